// File: rtl/rr_arbiter_mux.sv
// N-channel round-robin arbiter feeding a registered N-to-1 data mux with valid/ready output.
// Optional macro RR_ARBITER_MUX_FIXED_PRI_EN adds a fixed_pri input forcing lowest-index-first search.
module rr_arbiter_mux #(
  parameter int unsigned N_CH   = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned SEL_W  = $clog2(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_CH-1:0]        req,
  input  logic [N_CH*DATA_W-1:0] data_in,
  output logic [N_CH-1:0]        grant,
  output logic                   out_valid,
  input  logic                   out_ready,
`ifdef RR_ARBITER_MUX_FIXED_PRI_EN
  input  logic                   fixed_pri,
`endif
  output logic [DATA_W-1:0]      out_data,
  output logic [SEL_W-1:0]       out_sel
);

  localparam int unsigned LAST_CH = N_CH - 1;

  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [SEL_W-1:0]  sel_q, sel_d;

  logic              fp;
  logic              load;
  logic              hit;
  logic [SEL_W-1:0]  idx;
  logic [SEL_W-1:0]  cand;
  logic [DATA_W-1:0] sel_data;
  int unsigned       base;

`ifdef RR_ARBITER_MUX_FIXED_PRI_EN
  assign fp = fixed_pri;
`else
  assign fp = 1'b0;
`endif

  // Register is free when empty or being drained this edge; reset forces no grant.
  assign load = rst_n & (~valid_q | out_ready) & (|req);

  // Priority search from base+1 upward, wrapping; fixed priority treats base as the top channel.
  always_comb begin
    base = fp ? LAST_CH : 32'(ptr_q);
    hit  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      cand = SEL_W'((base + 1 + k) % N_CH);
      if (!hit && req[cand]) begin
        hit = 1'b1;
        idx = cand;
      end
    end
  end

  // Data mux and one-hot grant decode driven by the winning index.
  always_comb begin
    sel_data = '0;
    grant    = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (idx == SEL_W'(i)) begin
        sel_data = data_in[i*DATA_W +: DATA_W];
        grant[i] = load;
      end
    end
  end

  // Next-state for pointer and output register.
  always_comb begin
    ptr_d   = ptr_q;
    valid_d = valid_q;
    data_d  = data_q;
    sel_d   = sel_q;
    if (load) begin
      ptr_d   = idx;
      valid_d = 1'b1;
      data_d  = sel_data;
      sel_d   = idx;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= SEL_W'(LAST_CH);
      valid_q <= 1'b0;
      data_q  <= '0;
      sel_q   <= '0;
    end else begin
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_sel   = sel_q;

endmodule

// File: doc/rr_arbiter_mux.md
Name: rr_arbiter_mux

Overview:
Parametrised N-channel round-robin arbiter with a registered N-to-1 data multiplexer and a one-hot grant decoder. It is the sequential successor to the team's fixed 2/4/8-to-1 mux and 1/2-to-4 decoder cells. Requesting channels are granted fairly, one per cycle. The selected word is held in an output register under a valid/ready handshake. It sits between several producers and a single shared consumer, for example a display or UART path.

Parameters:
- N_CH, 4, number of input channels (2..16).
- DATA_W, 8, width of each channel's data word.
- SEL_W, $clog2(N_CH), width of the channel-index output (derived; do not override).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  N_CH  per-channel request; bit i means data_in slice i is valid.
- data_in  input  N_CH*DATA_W  packed channel data; channel i occupies bits [i*DATA_W +: DATA_W].
- grant  output  N_CH  one-hot combinational acknowledge; channel i is consumed at the edge where grant[i]=1.
- out_valid  output  1  output register holds an unconsumed word.
- out_ready  input  1  consumer accepts the word when out_valid & out_ready at an edge.
- out_data  output  DATA_W  registered selected word.
- out_sel  output  SEL_W  registered index of the channel that produced out_data.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_data=0, out_sel=0, ptr=N_CH-1.
  - Channel 0 therefore has top priority after reset.
  - grant=0 while rst_n=0.
  - Reset asserted mid-transfer drops the held word immediately; there is no partial completion.
- Internal state:
  - ptr (SEL_W bits): last granted channel.
  - Output register: out_valid, out_data, out_sel.
- load = (~out_valid | out_ready) & (|req).
  - The register may load in the same cycle its current word is accepted.
  - Sustained throughput is 1 word/cycle.
- Arbitration (combinational):
  - Search starts at ptr+1 mod N_CH and wraps through N_CH-1 to 0, ending at ptr.
  - The first set req bit wins; idx is its index.
  - grant = one-hot(idx) when load, else 0.
  - grant never has more than one bit set.
- On the edge with load=1: out_data <= data_in[idx], out_sel <= idx, out_valid <= 1, ptr <= idx.
- On the edge with out_valid & out_ready & ~|req: out_valid <= 0; out_data and out_sel hold their last value.
- On the edge with out_valid & ~out_ready (stall): all state holds and grant=0. This is backpressure; req lines must be held by producers.
- Latency: req asserted with the register free → grant the same cycle → out_valid/out_data at the next edge (1 cycle).
- Fairness: with all N_CH requests continuously high and out_ready=1, grants rotate 0,1,…,N_CH-1,0. No channel waits more than N_CH-1 grants.
- A single persistent requester is granted every cycle, including when it equals ptr.
- ptr does not change when there is no grant.
- data_in of a non-granted channel never affects outputs.

Optional Feature:
- Macro RR_ARBITER_MUX_FIXED_PRI_EN.
- When defined:
  - Adds input port fixed_pri (1 bit, after out_ready).
  - While fixed_pri=1, the search always starts at channel 0 (lowest index wins).
  - ptr still updates to idx.
  - While fixed_pri=0, behaviour is round-robin as above.
- When undefined: the port is absent and arbitration is always round-robin.

Test Plan:
- Reset check: rst_n=0 with req=4'b1111 → grant=0, out_valid=0, out_data=0, out_sel=0. After release with out_ready=1: first grant=4'b0001, then out_sel=0 at the next edge.
- Full rotation: N_CH=4, req=4'b1111, data_in={8'hD3,8'hC2,8'hB1,8'hA0}, out_ready=1 for 8 cycles → out_data sequence A0,B1,C2,D3,A0,B1,C2,D3, out_valid=1 every cycle after the first.
- Wrap and skip: ptr=2 (last grant ch2), req=4'b0011 → grant=4'b0001, out_sel=0. The next cycle with req=4'b0010 → grant=4'b0010.
- Backpressure: out_valid=1, out_data=8'hB1, out_ready=0 for 3 cycles with req=4'b1111 → grant=0, out_data stays B1, ptr unchanged. When out_ready=1 → B1 accepted and ch2 granted in the same cycle.
- Drain: req=0, out_valid=1, out_ready=1 → out_valid=0 at the next edge; out_data retains its last value.
- With RR_ARBITER_MUX_FIXED_PRI_EN, fixed_pri=1, req=4'b1010 held 4 cycles → grant=4'b0010 every cycle. Setting fixed_pri=0 → next grant=4'b1000.
